// File: rtl/rv_trap_ctrl_pkg.sv
// Shared definitions for the uRV machine-mode trap controller: CSR addresses,
// bit positions, interrupt cause codes and FSM state encoding.
package rv_trap_ctrl_pkg;

   localparam logic [11:0] CSR_ID_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_ID_MIE     = 12'h304;
   localparam logic [11:0] CSR_ID_MEPC    = 12'h341;
   localparam logic [11:0] CSR_ID_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_ID_MIP     = 12'h344;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MIP_MTIP_BIT     = 7;
   localparam int MIP_MEIP_BIT     = 11;

   localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
   localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

   localparam logic [31:0] MEPC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_TRAP = 1'b1
   } trap_state_e;

   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v                   = '0;
      v[MSTATUS_MIE_BIT]  = mie;
      v[MSTATUS_MPIE_BIT] = mpie;
      return v;
   endfunction

   // mip and mie share the same bit layout
   function automatic logic [31:0] irq_pack(input logic ext, input logic tmr);
      logic [31:0] v;
      v               = '0;
      v[MIP_MEIP_BIT] = ext;
      v[MIP_MTIP_BIT] = tmr;
      return v;
   endfunction

endpackage

// File: rtl/rv_trap_ctrl_irq_sync.sv
// Two-flop synchroniser for the external and timer interrupt lines,
// reduced to a straight wire when the lines are already in the core clock domain.
module rv_trap_ctrl_irq_sync #(
   parameter bit g_irq_sync = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   input  logic timer_irq_i,
   output logic meip_o,
   output logic mtip_o
);

   if (g_irq_sync) begin : g_sync
      logic [1:0] ext_q;
      logic [1:0] tmr_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            ext_q <= '0;
            tmr_q <= '0;
         end else begin
            ext_q <= {ext_q[0], irq_i};
            tmr_q <= {tmr_q[0], timer_irq_i};
         end
      end

      assign meip_o = ext_q[1];
      assign mtip_o = tmr_q[1];
   end else begin : g_bypass
      assign meip_o = irq_i;
      assign mtip_o = timer_irq_i;
   end

endmodule

// File: rtl/rv_trap_ctrl.sv
// Machine-mode trap controller: owns mstatus/mie/mepc/mcause, builds mip,
// sequences trap entry and MRET and produces the fetch redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | normal execution; enabled pending interrupts raise x_irq_o
// ST_TRAP | inside a trap handler; interrupt request held low
module rv_trap_ctrl
   import rv_trap_ctrl_pkg::*;
#(
   parameter logic [31:0] g_trap_vector = 32'h0000_0008,
   parameter bit          g_irq_sync    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        x_stall_i,
   input  logic        x_kill_i,
   input  logic        d_is_csr_i,
   input  logic [11:0] d_csr_sel_i,
   input  logic [31:0] x_csr_write_value_i,
   input  logic        x_exception_i,
   input  logic [3:0]  x_exception_cause_i,
   input  logic [31:0] x_exception_pc_i,
   input  logic        x_is_mret_i,
   input  logic        x_irq_take_i,
   input  logic        irq_i,
   input  logic        timer_irq_i,
   output logic        x_irq_o,
   output logic        x_trap_redirect_o,
   output logic [31:0] x_trap_pc_o,
   output logic [31:0] csr_mstatus_o,
   output logic [31:0] csr_mip_o,
   output logic [31:0] csr_mie_o,
   output logic [31:0] csr_mepc_o,
   output logic [31:0] csr_mcause_o
);

   trap_state_e state_q, state_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic        meie_q, meie_d;
   logic        mtie_q, mtie_d;
   logic [31:0] mepc_q, mepc_d;
   logic        mcause_intr_q, mcause_intr_d;
   logic [3:0]  mcause_code_q, mcause_code_d;
   logic        irq_q, irq_d;
   logic        redirect_q, redirect_d;
   logic [31:0] trap_pc_q, trap_pc_d;

   logic        meip, mtip;
   logic        pend_ext, pend_tmr;
   logic        upd, take_exc, take_irq, do_mret, do_csr;

   rv_trap_ctrl_irq_sync #(
      .g_irq_sync (g_irq_sync)
   ) u_irq_sync (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .irq_i       (irq_i),
      .timer_irq_i (timer_irq_i),
      .meip_o      (meip),
      .mtip_o      (mtip)
   );

   always_comb begin
      upd      = !x_stall_i && !x_kill_i;
      pend_ext = meip && meie_q;
      pend_tmr = mtip && mtie_q;
      take_exc = upd && x_exception_i;
      take_irq = upd && !take_exc && x_irq_take_i && irq_q && (state_q == ST_RUN);
      do_mret  = upd && !take_exc && !take_irq && x_is_mret_i;
      do_csr   = upd && !take_exc && !take_irq && !do_mret && d_is_csr_i;
   end

   always_comb begin
      state_d        = state_q;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      meie_d         = meie_q;
      mtie_d         = mtie_q;
      mepc_d         = mepc_q;
      mcause_intr_d  = mcause_intr_q;
      mcause_code_d  = mcause_code_q;
      redirect_d     = 1'b0;
      trap_pc_d      = trap_pc_q;

      if (take_exc || take_irq) begin
         mepc_d         = x_exception_pc_i & MEPC_ALIGN_MASK;
         mcause_intr_d  = take_irq;
         if (take_exc) begin
            mcause_code_d = x_exception_cause_i;
         end else begin
            mcause_code_d = pend_ext ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
         end
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
         state_d        = ST_TRAP;
         redirect_d     = 1'b1;
         trap_pc_d      = g_trap_vector;
      end else if (do_mret) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
         state_d        = ST_RUN;
         redirect_d     = 1'b1;
         trap_pc_d      = mepc_q;
      end else begin
         if (do_csr) begin
            case (d_csr_sel_i)
               CSR_ID_MSTATUS: begin
                  mstatus_mie_d  = x_csr_write_value_i[MSTATUS_MIE_BIT];
                  mstatus_mpie_d = x_csr_write_value_i[MSTATUS_MPIE_BIT];
               end
               CSR_ID_MIE: begin
                  meie_d = x_csr_write_value_i[MIP_MEIP_BIT];
                  mtie_d = x_csr_write_value_i[MIP_MTIP_BIT];
               end
               CSR_ID_MEPC: mepc_d = x_csr_write_value_i & MEPC_ALIGN_MASK;
               CSR_ID_MCAUSE: begin
                  mcause_intr_d = x_csr_write_value_i[31];
                  mcause_code_d = x_csr_write_value_i[3:0];
               end
               CSR_ID_MIP: ;
               default: ;
            endcase
         end
         // handler re-enabled interrupts by hand: leave TRAP on the following cycle
         if (upd && state_q == ST_TRAP && mstatus_mie_q) begin
            state_d = ST_RUN;
         end
      end

      // request follows the current registers; forced low while entering or inside TRAP
      irq_d = (state_d == ST_RUN) && mstatus_mie_q && (pend_ext || pend_tmr);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_RUN;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         meie_q         <= 1'b0;
         mtie_q         <= 1'b0;
         mepc_q         <= '0;
         mcause_intr_q  <= 1'b0;
         mcause_code_q  <= '0;
         irq_q          <= 1'b0;
         redirect_q     <= 1'b0;
         trap_pc_q      <= '0;
      end else begin
         state_q        <= state_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         meie_q         <= meie_d;
         mtie_q         <= mtie_d;
         mepc_q         <= mepc_d;
         mcause_intr_q  <= mcause_intr_d;
         mcause_code_q  <= mcause_code_d;
         irq_q          <= irq_d;
         redirect_q     <= redirect_d;
         trap_pc_q      <= trap_pc_d;
      end
   end

   assign x_irq_o           = irq_q;
   assign x_trap_redirect_o = redirect_q;
   assign x_trap_pc_o       = trap_pc_q;
   assign csr_mstatus_o     = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
   assign csr_mip_o         = irq_pack(meip, mtip);
   assign csr_mie_o         = irq_pack(meie_q, mtie_q);
   assign csr_mepc_o        = mepc_q;
   assign csr_mcause_o      = {mcause_intr_q, 27'h0, mcause_code_q};

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Self-checking bench for rv_trap_ctrl: CSR write table plus trap/MRET sequences,
// with redirect targets tracked through an expectation queue.
module tb_rv_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        x_stall_i, x_kill_i, d_is_csr_i;
   logic [11:0] d_csr_sel_i;
   logic [31:0] x_csr_write_value_i;
   logic        x_exception_i;
   logic [3:0]  x_exception_cause_i;
   logic [31:0] x_exception_pc_i;
   logic        x_is_mret_i, x_irq_take_i, irq_i, timer_irq_i;
   logic        x_irq_o, x_trap_redirect_o;
   logic [31:0] x_trap_pc_o, csr_mstatus_o, csr_mip_o, csr_mie_o, csr_mepc_o, csr_mcause_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   typedef struct {
      logic [11:0] sel;
      logic [31:0] wval;
      logic [31:0] e_mstatus;
      logic [31:0] e_mie;
      logic [31:0] e_mepc;
      logic [31:0] e_mcause;
   } csr_vec_t;

   csr_vec_t vecs[10];

   rv_trap_ctrl #(
      .g_trap_vector (32'h0000_0008),
      .g_irq_sync    (1'b1)
   ) dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .x_stall_i           (x_stall_i),
      .x_kill_i            (x_kill_i),
      .d_is_csr_i          (d_is_csr_i),
      .d_csr_sel_i         (d_csr_sel_i),
      .x_csr_write_value_i (x_csr_write_value_i),
      .x_exception_i       (x_exception_i),
      .x_exception_cause_i (x_exception_cause_i),
      .x_exception_pc_i    (x_exception_pc_i),
      .x_is_mret_i         (x_is_mret_i),
      .x_irq_take_i        (x_irq_take_i),
      .irq_i               (irq_i),
      .timer_irq_i         (timer_irq_i),
      .x_irq_o             (x_irq_o),
      .x_trap_redirect_o   (x_trap_redirect_o),
      .x_trap_pc_o         (x_trap_pc_o),
      .csr_mstatus_o       (csr_mstatus_o),
      .csr_mip_o           (csr_mip_o),
      .csr_mie_o           (csr_mie_o),
      .csr_mepc_o          (csr_mepc_o),
      .csr_mcause_o        (csr_mcause_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // redirect scoreboard: every pulse must match the oldest queued target
   always @(negedge clk) begin
      if (x_trap_redirect_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_redirect: got pc %h expected no redirect", x_trap_pc_o);
         end else begin
            chk("redirect_pc", x_trap_pc_o, exp_q.pop_front());
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      x_stall_i = 0; x_kill_i = 0; d_is_csr_i = 0; d_csr_sel_i = '0;
      x_csr_write_value_i = '0; x_exception_i = 0; x_exception_cause_i = '0;
      x_exception_pc_i = '0; x_is_mret_i = 0; x_irq_take_i = 0;
   endtask

   task automatic csr_wr(input logic [11:0] sel, input logic [31:0] val);
      d_is_csr_i = 1; d_csr_sel_i = sel; x_csr_write_value_i = val;
      cyc();
      idle();
   endtask

   task automatic check_all(input string tag, input logic [31:0] ms, input logic [31:0] me,
                            input logic [31:0] pc, input logic [31:0] mc);
      chk({tag, "_mstatus"}, csr_mstatus_o, ms);
      chk({tag, "_mie"}, csr_mie_o, me);
      chk({tag, "_mepc"}, csr_mepc_o, pc);
      chk({tag, "_mcause"}, csr_mcause_o, mc);
   endtask

   initial begin
      vecs[0] = '{A_MSTATUS, 32'hFFFF_FFFF, 32'h88, 32'h000, 32'h0000, 32'h0000_0000};
      vecs[1] = '{A_MIE,     32'hFFFF_FFFF, 32'h88, 32'h880, 32'h0000, 32'h0000_0000};
      vecs[2] = '{A_MEPC,    32'h0000_1237, 32'h88, 32'h880, 32'h1234, 32'h0000_0000};
      vecs[3] = '{A_MCAUSE,  32'h8000_00FB, 32'h88, 32'h880, 32'h1234, 32'h8000_000B};
      vecs[4] = '{A_MIP,     32'hFFFF_FFFF, 32'h88, 32'h880, 32'h1234, 32'h8000_000B};
      vecs[5] = '{A_MSTATUS, 32'h0000_0080, 32'h80, 32'h880, 32'h1234, 32'h8000_000B};
      vecs[6] = '{A_MIE,     32'h0000_0080, 32'h80, 32'h080, 32'h1234, 32'h8000_000B};
      vecs[7] = '{A_MCAUSE,  32'h0000_0003, 32'h80, 32'h080, 32'h1234, 32'h0000_0003};
      vecs[8] = '{12'h305,   32'hFFFF_FFFF, 32'h80, 32'h080, 32'h1234, 32'h0000_0003};
      vecs[9] = '{A_MSTATUS, 32'h0000_0000, 32'h00, 32'h080, 32'h1234, 32'h0000_0003};

      idle();
      irq_i = 0; timer_irq_i = 0;
      rst_i = 1;
      repeat (3) cyc();
      rst_i = 0;
      check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
      chk("reset_mip", csr_mip_o, 32'h0);
      chk("reset_irq", {31'h0, x_irq_o}, 32'h0);
      chk("reset_redirect", {31'h0, x_trap_redirect_o}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         csr_wr(vecs[i].sel, vecs[i].wval);
         check_all($sformatf("vec%0d", i), vecs[i].e_mstatus, vecs[i].e_mie,
                   vecs[i].e_mepc, vecs[i].e_mcause);
         chk($sformatf("vec%0d_mip", i), csr_mip_o, 32'h0);
      end

      // timer interrupt through the synchroniser, then taken
      csr_wr(A_MIE, 32'h880);
      csr_wr(A_MSTATUS, 32'h8);
      timer_irq_i = 1;
      cyc(); cyc();
      chk("irq_lat2", {31'h0, x_irq_o}, 32'h0);
      chk("mip_timer", csr_mip_o, 32'h80);
      cyc();
      chk("irq_lat3", {31'h0, x_irq_o}, 32'h1);
      x_irq_take_i = 1; x_exception_pc_i = 32'h100; exp_q.push_back(32'h8);
      cyc(); idle();
      check_all("take_tmr", 32'h80, 32'h880, 32'h100, 32'h8000_0007);
      chk("take_tmr_irq", {31'h0, x_irq_o}, 32'h0);
      cyc();

      // MRET back to RUN re-raises the still pending timer
      x_is_mret_i = 1; exp_q.push_back(32'h100);
      cyc(); idle();
      chk("mret1_mstatus", csr_mstatus_o, 32'h88);
      chk("mret1_irq_lo", {31'h0, x_irq_o}, 32'h0);
      cyc();
      chk("mret1_irq_rearm", {31'h0, x_irq_o}, 32'h1);

      // external beats timer
      irq_i = 1;
      repeat (3) cyc();
      chk("mip_both", csr_mip_o, 32'h880);
      x_irq_take_i = 1; x_exception_pc_i = 32'h200; exp_q.push_back(32'h8);
      cyc(); idle();
      check_all("take_ext", 32'h80, 32'h880, 32'h200, 32'h8000_000B);
      irq_i = 0; timer_irq_i = 0;
      x_is_mret_i = 1; exp_q.push_back(32'h200);
      cyc(); idle();
      chk("mret2_mstatus", csr_mstatus_o, 32'h88);
      repeat (3) cyc();
      chk("lines_low_irq", {31'h0, x_irq_o}, 32'h0);

      // exception beats a same-cycle CSR write
      x_exception_i = 1; x_exception_cause_i = 4'd11; x_exception_pc_i = 32'h206;
      d_is_csr_i = 1; d_csr_sel_i = A_MSTATUS; x_csr_write_value_i = 32'h8;
      exp_q.push_back(32'h8);
      cyc(); idle();
      check_all("exc_ecall", 32'h80, 32'h880, 32'h204, 32'h0000_000B);
      timer_irq_i = 1;
      repeat (4) cyc();
      chk("trap_irq_masked", {31'h0, x_irq_o}, 32'h0);
      x_is_mret_i = 1; exp_q.push_back(32'h204);
      cyc(); idle();
      chk("mret3_mstatus", csr_mstatus_o, 32'h88);
      cyc();
      chk("mret3_irq", {31'h0, x_irq_o}, 32'h1);

      // stall / kill suppress every update
      x_stall_i = 1; x_exception_i = 1; x_exception_cause_i = 4'd2; x_exception_pc_i = 32'h300;
      cyc(); idle();
      check_all("stall_exc", 32'h88, 32'h880, 32'h204, 32'h0000_000B);
      x_kill_i = 1; x_irq_take_i = 1; x_exception_pc_i = 32'h300;
      cyc(); idle();
      check_all("kill_take", 32'h88, 32'h880, 32'h204, 32'h0000_000B);
      x_stall_i = 1;
      csr_wr(A_MSTATUS, 32'h0);
      chk("stall_csr", csr_mstatus_o, 32'h88);
      x_irq_take_i = 1; x_exception_pc_i = 32'h300; exp_q.push_back(32'h8);
      cyc(); idle();
      check_all("take_tmr2", 32'h80, 32'h880, 32'h300, 32'h8000_0007);
      x_kill_i = 1; x_is_mret_i = 1;
      cyc(); idle();
      chk("kill_mret", csr_mstatus_o, 32'h80);
      x_irq_take_i = 1; x_exception_pc_i = 32'h340;
      cyc(); idle();
      chk("take_in_trap_mepc", csr_mepc_o, 32'h300);

      // handler sets MIE by CSR write: leaves TRAP, request returns
      csr_wr(A_MSTATUS, 32'h88);
      chk("trap_csr_mstatus", csr_mstatus_o, 32'h88);
      chk("trap_csr_irq_lo", {31'h0, x_irq_o}, 32'h0);
      cyc();
      chk("trap_exit_irq", {31'h0, x_irq_o}, 32'h1);

      // MRET while in RUN
      csr_wr(A_MSTATUS, 32'h08);
      x_is_mret_i = 1; exp_q.push_back(32'h300);
      cyc(); idle();
      chk("mret_run_mstatus", csr_mstatus_o, 32'h80);
      cyc();
      chk("mret_run_irq_off", {31'h0, x_irq_o}, 32'h0);
      csr_wr(A_MSTATUS, 32'h08);
      cyc();
      chk("run_after_mret_irq", {31'h0, x_irq_o}, 32'h1);

      // line drops before take: request falls, take ignored
      timer_irq_i = 0;
      repeat (3) cyc();
      chk("irq_drop", {31'h0, x_irq_o}, 32'h0);
      x_irq_take_i = 1; x_exception_pc_i = 32'h400;
      cyc(); idle();
      check_all("take_no_irq", 32'h08, 32'h880, 32'h300, 32'h8000_0007);

      // reset while in TRAP
      x_exception_i = 1; x_exception_cause_i = 4'd3; x_exception_pc_i = 32'h500;
      exp_q.push_back(32'h8);
      cyc(); idle();
      check_all("exc_ebreak", 32'h80, 32'h880, 32'h500, 32'h0000_0003);
      rst_i = 1;
      cyc();
      rst_i = 0;
      check_all("rst_trap", 32'h0, 32'h0, 32'h0, 32'h0);
      chk("rst_trap_irq", {31'h0, x_irq_o}, 32'h0);
      chk("rst_trap_redirect", {31'h0, x_trap_redirect_o}, 32'h0);
      rst_i = 1; x_exception_i = 1; x_exception_pc_i = 32'h600;
      cyc(); idle();
      rst_i = 0;
      chk("rst_exc_mepc", csr_mepc_o, 32'h0);
      chk("rst_exc_redirect", {31'h0, x_trap_redirect_o}, 32'h0);

      repeat (2) cyc();
      chk("redirects_outstanding", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
